// File: rtl/fpu_pkg.sv
// Shared FP16 constants and FSM state encoding for the FPU datapath blocks.
// FPU_DIV_ROUND_EN selects 13 quotient bits (guard bit) instead of 12.
package fpu_pkg;

   localparam int EXP_W  = 5;
   localparam int MANT_W = 10;
   localparam int BIAS   = 15;

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;
   localparam logic [15:0] NEG_INF = 16'hFC00;

`ifdef FPU_DIV_ROUND_EN
   localparam int QBITS = 13;
`else
   localparam int QBITS = 12;
`endif

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_DIVIDE    = 3'd2;
   localparam logic [2:0] ST_NORMALIZE = 3'd3;
   localparam logic [2:0] ST_PACK      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      DECODE    = ST_DECODE,
      DIVIDE    = ST_DIVIDE,
      NORMALIZE = ST_NORMALIZE,
      PACK      = ST_PACK
   } fpu_state_t;

endpackage

// File: rtl/fpu_fp16_classify.sv
// Combinational FP16 field decode and classification; denormals flush to zero.
module fpu_fp16_classify
   import fpu_pkg::*;
(
   input  logic [15:0]       word,
   output logic              sign,
   output logic [EXP_W-1:0]  exp_field,
   output logic [MANT_W:0]   frac,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_zero
);

   logic exp_ones;
   logic exp_zeros;
   logic mant_nz;

   assign exp_ones  = &word[14:10];
   assign exp_zeros = ~|word[14:10];
   assign mant_nz   = |word[9:0];

   assign sign      = word[15];
   assign exp_field = word[14:10];
   assign frac      = exp_zeros ? '0 : {1'b1, word[9:0]};
   assign is_nan    = exp_ones & mant_nz;
   assign is_inf    = exp_ones & ~mant_nz;
   assign is_zero   = exp_zeros;

endmodule

// File: rtl/fpu_div_iterative.sv
// FP16 divider: restoring radix-2 mantissa division, one quotient bit per cycle.
// Define FPU_DIV_ROUND_EN for round-to-nearest-even (one extra iteration).
module fpu_div_iterative
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        valid_out,
   output logic [15:0] result
);

   fpu_state_t state, state_next;

   logic [15:0]       a_reg, b_reg;
   logic [MANT_W+1:0] rem_reg;
   logic [MANT_W:0]   divisor_reg;
   logic [QBITS-1:0]  q_reg;
   logic [3:0]        cnt_reg;
   logic signed [6:0] exp_raw_reg, exp_reg;
   logic [MANT_W-1:0] mant_reg;
   logic              sign_reg, nan_case_reg, inf_case_reg, zero_case_reg;

   logic              sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W:0]   fa, fb;

   fpu_fp16_classify u_cls_a (.word(a_reg), .sign(sa), .exp_field(ea), .frac(fa),
                              .is_nan(nan_a), .is_inf(inf_a), .is_zero(zero_a));
   fpu_fp16_classify u_cls_b (.word(b_reg), .sign(sb), .exp_field(eb), .frac(fb),
                              .is_nan(nan_b), .is_inf(inf_b), .is_zero(zero_b));

   logic signed [6:0] exp_raw_calc;
   assign exp_raw_calc = 7'({2'b00, ea}) - 7'({2'b00, eb}) + 7'(BIAS);

   // Trial subtraction carries one extra bit so its MSB is the borrow.
   logic [MANT_W+2:0] trial;
   logic              trial_ok;
   logic [MANT_W+1:0] rem_kept;
   assign trial    = {1'b0, rem_reg} - {2'b00, divisor_reg};
   assign trial_ok = ~trial[MANT_W+2];
   assign rem_kept = trial_ok ? trial[MANT_W+1:0] : rem_reg;

   logic [MANT_W-1:0] norm_mant;
   logic signed [6:0] norm_exp;

`ifdef FPU_DIV_ROUND_EN
   logic              q_hi, guard, sticky, round_up;
   logic [MANT_W-1:0] mant_t;
   logic [MANT_W:0]   mant_sum;
   logic signed [6:0] exp_t;
   assign q_hi      = q_reg[12];
   assign mant_t    = q_hi ? q_reg[11:2] : q_reg[10:1];
   assign guard     = q_hi ? q_reg[1] : q_reg[0];
   assign sticky    = (q_hi & q_reg[0]) | (|rem_reg);
   assign round_up  = guard & (sticky | mant_t[0]);
   assign mant_sum  = {1'b0, mant_t} + 11'(round_up);
   assign exp_t     = q_hi ? exp_raw_reg : exp_raw_reg - 7'sd1;
   assign norm_exp  = exp_t + 7'(mant_sum[MANT_W]);
   assign norm_mant = mant_sum[MANT_W-1:0];
`else
   assign norm_mant = q_reg[11] ? q_reg[10:1] : q_reg[9:0];
   assign norm_exp  = q_reg[11] ? exp_raw_reg : exp_raw_reg - 7'sd1;
`endif

   logic [15:0] pack_word;
   always_comb begin
      pack_word = {sign_reg, exp_reg[4:0], mant_reg};
      if (nan_case_reg)           pack_word = QNAN;
      else if (inf_case_reg)      pack_word = {sign_reg, 5'h1F, 10'h000};
      else if (zero_case_reg)     pack_word = {sign_reg, 15'h0000};
      else if (exp_reg >= 7'sd31) pack_word = {sign_reg, 5'h1F, 10'h000};
      else if (exp_reg <= 7'sd0)  pack_word = {sign_reg, 15'h0000};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (valid_in) state_next = DECODE;
         DECODE:    state_next = DIVIDE;
         DIVIDE:    if (cnt_reg == 4'(QBITS - 1)) state_next = NORMALIZE;
         NORMALIZE: state_next = PACK;
         PACK:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (valid_in) begin
               a_reg <= a;
               b_reg <= b;
            end
         end
         DECODE: begin
            rem_reg       <= {1'b0, fa};
            divisor_reg   <= fb;
            q_reg         <= '0;
            cnt_reg       <= '0;
            sign_reg      <= sa ^ sb;
            exp_raw_reg   <= exp_raw_calc;
            nan_case_reg  <= nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b);
            inf_case_reg  <= inf_a | zero_b;
            zero_case_reg <= zero_a | inf_b;
         end
         DIVIDE: begin
            rem_reg <= {rem_kept[MANT_W:0], 1'b0};
            q_reg   <= {q_reg[QBITS-2:0], trial_ok};
            cnt_reg <= cnt_reg + 4'd1;
         end
         NORMALIZE: begin
            mant_reg <= norm_mant;
            exp_reg  <= norm_exp;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         result    <= 16'h0000;
      end else begin
         valid_out <= 1'b0;
         if (state == PACK) begin
            valid_out <= 1'b1;
            result    <= pack_word;
         end
      end
   end

endmodule

// File: tb/tb_fpu_div_iterative.sv
// Directed-vector bench for fpu_div_iterative: results, latency, strobe
// filtering and mid-operation reset abort.
module tb_fpu_div_iterative;

`ifdef FPU_DIV_ROUND_EN
   localparam int LAT = 16;
   localparam logic [15:0] RND_EXP = 16'h40CD;
`else
   localparam int LAT = 15;
   localparam logic [15:0] RND_EXP = 16'h40CC;
`endif

   localparam int NV = 15;
   localparam logic [15:0] VA [NV] = '{16'h4200, 16'h3C00, 16'h3C00, 16'hBC00, 16'h0000,
                                       16'h7C00, 16'h7BFF, 16'h0400, 16'h0001, 16'hC200,
                                       16'h7E01, 16'h3C00, 16'h4200, 16'hFC00, 16'h8000};
   localparam logic [15:0] VB [NV] = '{16'h3E00, 16'h4200, 16'h0000, 16'h0000, 16'h0000,
                                       16'h7C00, 16'h3800, 16'h4000, 16'h3C00, 16'h3E00,
                                       16'h3C00, 16'h7C00, 16'h3D00, 16'h3C00, 16'h3C00};
   localparam logic [15:0] VQ [NV] = '{16'h4000, 16'h3555, 16'h7C00, 16'hFC00, 16'h7E00,
                                       16'h7E00, 16'h7C00, 16'h0000, 16'h0000, 16'hC000,
                                       16'h7E00, 16'h0000, RND_EXP,  16'hFC00, 16'h8000};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        valid_out;
   logic [15:0] result;

   int n_vec = 0;
   int n_bad = 0;

   fpu_div_iterative dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
      .busy(busy), .valid_out(valid_out), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Call on a falling edge; returns on the falling edge inside the valid_out cycle
   // so the next call exercises the earliest back-to-back accept.
   task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic [15:0] want, input bit hammer);
      int k;
      bit seen;
      bit stable;
      logic [15:0] prev;
      a = op_a;
      b = op_b;
      valid_in = 1'b1;
      @(posedge clk);
      k = 0;
      seen = 0;
      stable = 1;
      prev = result;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (hammer) begin
            a = 16'h3C00;
            b = 16'h3C00;
            valid_in = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         if (k == 1) begin
            check_val({tag, "/prev_pulse_low"}, 16'(valid_out), 16'h0000);
            check_val({tag, "/busy_during"}, 16'(busy), 16'h0001);
         end
         if (valid_out) seen = 1;
         else if (result !== prev) stable = 0;
      end
      valid_in = 1'b0;
      check_val({tag, "/latency"}, 16'(k - 1), 16'(LAT));
      check_val({tag, "/result"}, result, want);
      check_val({tag, "/busy_after"}, 16'(busy), 16'h0000);
      if (hammer) check_val({tag, "/result_stable"}, 16'(stable), 16'h0001);
   endtask

   task automatic count_pulses(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (valid_out) cnt++;
      end
   endtask

   initial begin
      int pulses;
      repeat (3) @(negedge clk);
      check_val("reset/valid_out", 16'(valid_out), 16'h0000);
      check_val("reset/busy", 16'(busy), 16'h0000);
      check_val("reset/result", result, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("vec%0d %h/%h", i, VA[i], VB[i]), VA[i], VB[i], VQ[i], 1'b0);
      end

      run_op("hammer 3c00/4200", 16'h3C00, 16'h4200, 16'h3555, 1'b1);
      count_pulses(20, pulses);
      check_val("hammer/extra_pulses", 16'(pulses), 16'h0000);

      // Abort an operation with reset on edge N+7.
      a = 16'h4200;
      b = 16'h3E00;
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_val("abort/valid_out", 16'(valid_out), 16'h0000);
      check_val("abort/result", result, 16'h0000);
      check_val("abort/busy", 16'(busy), 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_pulses(20, pulses);
      check_val("abort/no_pulse", 16'(pulses), 16'h0000);
      check_val("abort/result_held", result, 16'h0000);

      run_op("post_reset 4200/3e00", 16'h4200, 16'h3E00, 16'h4000, 1'b0);
      @(negedge clk);
      check_val("final/pulse_width", 16'(valid_out), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fpu_div_iterative.md
Name: fpu_div_iterative

Overview:
FP16 (IEEE 754 binary16) divider. It is the inverse operation of the team's pipelined FP16 multiplier and shares that multiplier's valid_in/valid_out handshake and special-value conventions.
- Computes result = a / b using a restoring radix-2 mantissa divider, one quotient bit per cycle.
- Fixed latency; one operation in flight at a time.
- Sits beside the multiplier in the FPU datapath of the TinyQV peripheral.

Parameters:
- QNAN, 16'h7E00, canonical quiet-NaN pattern returned for every NaN result.
- QBITS, 12, quotient bits produced by the DIVIDE state. Must stay 12 unless FPU_DIV_ROUND_EN is defined (see below).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, operand strobe; sampled only in IDLE.
- a, input, 16, dividend (FP16).
- b, input, 16, divisor (FP16).
- busy, output, 1, high whenever state != IDLE.
- valid_out, output, 1, one-cycle pulse marking result valid.
- result, output, 16, quotient (FP16); holds its value until the next PACK.

Behaviour:
- Reset (async, rst_n low): state=IDLE, valid_out=0, busy=0, result=16'h0000. Internal datapath registers need not be reset.
- Reset asserted mid-operation aborts the operation. No valid_out is produced for it.
- State machine: IDLE -> DECODE -> DIVIDE (QBITS cycles, 4-bit iteration counter) -> NORMALIZE -> PACK -> IDLE.
- IDLE:
  - valid_out <= 0.
  - If valid_in: capture a and b, go to DECODE.
  - valid_in is ignored in every other state. There is no backpressure; the producer must watch busy.
- Latency: operands are captured on edge N; valid_out is high for the single cycle after edge N+15, together with result. Latency is fixed and identical for special cases.
- Earliest back-to-back accept is on the edge after the valid_out cycle. The IDLE return and a new capture can coincide on that edge.
- DECODE:
  - Extract sign, exponent and fraction for each operand. frac = {1, mant} for normal operands.
  - Denormal inputs (exp=0, mant!=0) are flushed to zero and classed as zero.
  - Classify each operand as nan, inf or zero.
- DIVIDE:
  - Remainder register starts at frac_a. Each cycle: trial-subtract frac_b; quotient bit = 1 if no borrow; restore on borrow; shift left.
  - After 12 cycles q = floor(frac_a * 2^11 / frac_b), range 0x400..0xFFF.
  - In parallel: exp_raw = exp_a - exp_b + 15, as 7-bit signed; sign = sign_a ^ sign_b.
- NORMALIZE:
  - If q[11]=1: mant = q[10:1], exp = exp_raw.
  - Else: mant = q[9:0], exp = exp_raw - 1.
  - Default rounding is truncation.
- PACK priority, highest first:
  1. NaN: any operand is NaN, or 0/0, or inf/inf -> QNAN.
  2. a is inf, or b is zero -> {sign, 5'h1F, 10'h0}.
  3. a is zero, or b is inf -> {sign, 15'h0}.
  4. exp >= 31 -> signed infinity (overflow).
  5. exp <= 0 -> signed zero. There are no denormal outputs.
  6. Otherwise -> {sign, exp[4:0], mant}.
- NaN sign is always 0.

Optional Feature:
FPU_DIV_ROUND_EN
- Defined:
  - DIVIDE runs 13 iterations, producing one guard bit.
  - Sticky bit = final remainder != 0.
  - Round to nearest, ties to even.
  - A mantissa carry-out increments exp; if the new exp reaches 31, the result is signed inf.
  - Latency becomes N+16.
- Undefined: truncation, 12 iterations, latency N+15.

Decomposition:
- Package fpu_pkg holds:
  - FP16 field widths (EXP_W=5, MANT_W=10) and BIAS=15.
  - QNAN, POS_INF, NEG_INF constants.
  - The state-encoding localparams, which the multiplier shares.
- One natural sub-module, fpu_fp16_classify: combinational decode of one FP16 word into sign, exp, frac, is_nan, is_inf and is_zero. It is instantiated twice here and is reusable by the multiplier.

Test Plan:
- 0x4200 / 0x3E00 (3.0/1.5) -> result 0x4000 at exactly edge N+15; valid_out high for one cycle; busy low afterwards.
- 0x3C00 / 0x4200 (1/3) -> 0x3555, with the macro both undefined and defined. With the macro defined, latency is N+16.
- 0x3C00 / 0x0000 -> 0x7C00. 0xBC00 / 0x0000 -> 0xFC00. 0x0000 / 0x0000 -> 0x7E00. 0x7C00 / 0x7C00 -> 0x7E00.
- 0x7BFF / 0x3800 (overflow) -> 0x7C00. 0x0400 / 0x4000 (underflow) -> 0x0000. 0x0001 / 0x3C00 (denormal input) -> 0x0000.
- Pulse valid_in every cycle during an operation -> extra strobes are ignored, only one valid_out is produced, and result is unchanged until that valid_out.
- Assert rst_n low at N+7 -> valid_out stays 0, result=0x0000, state=IDLE. A new operation started after reset completes correctly.
